sketch_counter_update: RTL and testbench

Read-modify-write counter engine sitting directly downstream of the hash-and-measure stage. It accepts one counter-update request per match (SRAM word address, update function, operand) and queues it. It then serially reads the 36-bit SRAM word, applies the function to the 32-bit counter field and writes the result back through a request/ack SRAM port. It also keeps an update count and a saturation count for software.

---
 rtl/sketch_counter_update_pkg.sv | 24 ++
 rtl/fallthrough_small_fifo.sv | 62 ++++++
 rtl/sketch_counter_update.sv | 148 ++++++++++++++
 tb/tb_sketch_counter_update.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sketch_counter_update_pkg.sv
// Shared encodings for the sketch counter read-modify-write engine.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: update function codes, engine FSM states, counter field width.
package sketch_counter_update_pkg;

  localparam int COUNTER_WIDTH = 32;
  localparam int FUNC_WIDTH    = 2;

  typedef enum logic [FUNC_WIDTH-1:0] {
    FUNC_ADD = 2'd0,
    FUNC_MAX = 2'd1,
    FUNC_SET = 2'd2,
    FUNC_INC = 2'd3
  } func_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_REQ  = 2'd1,
    ST_RD_WAIT = 2'd2,
    ST_WR_REQ  = 2'd3
  } state_t;

endpackage

// File: rtl/fallthrough_small_fifo.sv
// Small first-word-fall-through FIFO: head entry is visible on dout whenever !empty.
// Latency: a word written in cycle t is visible on dout in cycle t+1.
// Backpressure: full flags no space; a write while full is taken only when a read happens in the same cycle.
// Ports: clk/reset (sync, active-high); din/wr_en write side; dout/rd_en read side; full/empty status.
module fallthrough_small_fifo #(
  parameter int WIDTH          = 72,
  parameter int MAX_DEPTH_BITS = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 1 << MAX_DEPTH_BITS;

  logic [WIDTH-1:0]          mem [DEPTH];
  logic [MAX_DEPTH_BITS-1:0] wr_ptr;
  logic [MAX_DEPTH_BITS-1:0] rd_ptr;
  logic [MAX_DEPTH_BITS:0]   depth;
  logic                      do_wr;
  logic                      do_rd;

  assign empty = (depth == '0);
  assign full  = (depth == (MAX_DEPTH_BITS+1)'(DEPTH));
  assign dout  = mem[rd_ptr];

  // A read frees its slot in the same cycle, so a write into a full FIFO is safe then.
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      depth  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_wr, do_rd})
        2'b10:   depth <= depth + 1'b1;
        2'b01:   depth <= depth - 1'b1;
        default: depth <= depth;
      endcase
    end
  end

endmodule

// File: rtl/sketch_counter_update.sv
// Queued read-modify-write engine for 32-bit counters held in 36-bit SRAM words.
// Latency: push into an idle engine -> read request 2 cycles later; write request 1 cycle after read data.
// Backpressure: req_rdy = !queue_full; sram_req held until sram_ack, one SRAM access outstanding at a time.
// Ports: clk/reset (sync, active-high); req_vld/req_rdy/req_addr/req_func/req_value update request;
//        sram_req/sram_ack/sram_rd_wr_L/sram_addr/sram_wr_data/sram_rd_data/sram_rd_vld SRAM port;
//        busy, num_updates, num_saturated status for software.
module sketch_counter_update
  import sketch_counter_update_pkg::*;
#(
  parameter int SRAM_ADDR_WIDTH = 19,
  parameter int SRAM_DATA_WIDTH = 36,
  parameter int FIFO_DEPTH_BITS = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_vld,
  output logic                       req_rdy,
  input  logic [SRAM_ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0]                 req_func,
  input  logic [31:0]                req_value,
  output logic                       sram_req,
  input  logic                       sram_ack,
  output logic                       sram_rd_wr_L,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
  output logic [SRAM_DATA_WIDTH-1:0] sram_wr_data,
  input  logic [SRAM_DATA_WIDTH-1:0] sram_rd_data,
  input  logic                       sram_rd_vld,
  output logic                       busy,
  output logic [31:0]                num_updates,
  output logic [31:0]                num_saturated
);

  localparam int QW = SRAM_ADDR_WIDTH + FUNC_WIDTH + COUNTER_WIDTH;

  // Request queue: {addr, func, value}
  logic [QW-1:0] fifo_din;
  logic [QW-1:0] fifo_dout;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;

  state_t                   state;
  func_t                    work_func;
  logic [COUNTER_WIDTH-1:0] work_value;

  logic [COUNTER_WIDTH-1:0] old_cnt;
  logic [COUNTER_WIDTH-1:0] operand;
  logic [COUNTER_WIDTH:0]   alu_sum;
  logic [COUNTER_WIDTH-1:0] alu_result;
  logic                     alu_sat;
  logic                     rd_data_unused;

  assign req_rdy   = !fifo_full;
  assign fifo_push = req_vld && req_rdy;
  assign fifo_din  = {req_addr, req_func, req_value};
  assign fifo_pop  = (state == ST_IDLE) && !fifo_empty;
  assign busy      = (state != ST_IDLE) || !fifo_empty;

  fallthrough_small_fifo #(
    .WIDTH          (QW),
    .MAX_DEPTH_BITS (FIFO_DEPTH_BITS)
  ) u_req_fifo (
    .clk   (clk),
    .reset (reset),
    .din   (fifo_din),
    .wr_en (fifo_push),
    .rd_en (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // The tag bits above the counter field are rewritten as zero, never merged.
  assign old_cnt        = sram_rd_data[COUNTER_WIDTH-1:0];
  assign rd_data_unused = ^sram_rd_data[SRAM_DATA_WIDTH-1:COUNTER_WIDTH];

  always_comb begin
    operand    = (work_func == FUNC_INC) ? COUNTER_WIDTH'(1) : work_value;
    alu_sum    = {1'b0, old_cnt} + {1'b0, operand};
    alu_sat    = 1'b0;
    alu_result = work_value;
    case (work_func)
      FUNC_ADD, FUNC_INC: begin
        alu_sat    = alu_sum[COUNTER_WIDTH];
        alu_result = alu_sum[COUNTER_WIDTH] ? '1 : alu_sum[COUNTER_WIDTH-1:0];
      end
      FUNC_MAX: alu_result = (old_cnt > work_value) ? old_cnt : work_value;
      default:  alu_result = work_value;
    endcase
  end

  // sram_addr doubles as the work-register address: it is loaded at pop and
  // held through both accesses, which keeps it stable while sram_req is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      sram_req      <= 1'b0;
      sram_rd_wr_L  <= 1'b1;
      sram_addr     <= '0;
      sram_wr_data  <= '0;
      work_func     <= FUNC_ADD;
      work_value    <= '0;
      num_updates   <= '0;
      num_saturated <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            sram_addr    <= fifo_dout[QW-1 -: SRAM_ADDR_WIDTH];
            work_func    <= func_t'(fifo_dout[COUNTER_WIDTH +: FUNC_WIDTH]);
            work_value   <= fifo_dout[COUNTER_WIDTH-1:0];
            sram_req     <= 1'b1;
            sram_rd_wr_L <= 1'b1;
            state        <= ST_RD_REQ;
          end
        end
        ST_RD_REQ: begin
          if (sram_ack) begin
            sram_req <= 1'b0;
            state    <= ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          if (sram_rd_vld) begin
            sram_wr_data <= {{(SRAM_DATA_WIDTH-COUNTER_WIDTH){1'b0}}, alu_result};
            sram_req     <= 1'b1;
            sram_rd_wr_L <= 1'b0;
            if (alu_sat) begin
              num_saturated <= num_saturated + 32'd1;
            end
            state <= ST_WR_REQ;
          end
        end
        ST_WR_REQ: begin
          if (sram_ack) begin
            sram_req     <= 1'b0;
            sram_rd_wr_L <= 1'b1;
            num_updates  <= num_updates + 32'd1;
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sketch_counter_update.sv
// Testbench for sketch_counter_update: SRAM responder with random latencies plus a
// transaction-level counter model; scenario tasks compare retired accesses and status.
// Ports: none.
module tb_sketch_counter_update;
  import sketch_counter_update_pkg::*;

  localparam int AW = 19;
  localparam int DW = 36;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_vld;
  logic          req_rdy;
  logic [AW-1:0] req_addr;
  logic [1:0]    req_func;
  logic [31:0]   req_value;
  logic          sram_req;
  logic          sram_ack;
  logic          sram_rd_wr_L;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wr_data;
  logic [DW-1:0] sram_rd_data;
  logic          sram_rd_vld;
  logic          busy;
  logic [31:0]   num_updates;
  logic [31:0]   num_saturated;

  sketch_counter_update #(
    .SRAM_ADDR_WIDTH (AW),
    .SRAM_DATA_WIDTH (DW),
    .FIFO_DEPTH_BITS (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_vld       (req_vld),
    .req_rdy       (req_rdy),
    .req_addr      (req_addr),
    .req_func      (req_func),
    .req_value     (req_value),
    .sram_req      (sram_req),
    .sram_ack      (sram_ack),
    .sram_rd_wr_L  (sram_rd_wr_L),
    .sram_addr     (sram_addr),
    .sram_wr_data  (sram_wr_data),
    .sram_rd_data  (sram_rd_data),
    .sram_rd_vld   (sram_rd_vld),
    .busy          (busy),
    .num_updates   (num_updates),
    .num_saturated (num_saturated)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- SRAM responder state ----------------
  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } acc_t;

  acc_t          log_q [$];
  int            wr_lat_q [$];
  logic [DW-1:0] mem [logic [AW-1:0]];
  int            ack_min = 0, ack_max = 0, rd_min = 0, rd_max = 0;
  bit            spur_en = 0;
  int            proto_err = 0;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          exp_q [$];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  int            ref_upd = 0;
  int            ref_sat = 0;

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    return mem.exists(a) ? mem[a] : '0;
  endfunction

  function automatic void set_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
    mem[a]     = d;
    ref_mem[a] = d;
  endfunction

  // Updates retire in arrival order, so applying each accepted request to the
  // model memory immediately yields the exact sequence of expected write-backs.
  function automatic void model_accept(input logic [AW-1:0] a, input logic [1:0] f,
                                       input logic [31:0] v);
    logic [DW-1:0]   w;
    longint unsigned old;
    longint unsigned r;
    exp_t            e;
    w   = ref_mem.exists(a) ? ref_mem[a] : '0;
    old = longint'(w[31:0]);
    case (f)
      FUNC_ADD: r = old + longint'(v);
      FUNC_INC: r = old + 1;
      FUNC_MAX: r = (old > longint'(v)) ? old : longint'(v);
      default:  r = longint'(v);
    endcase
    if (r > 64'h0000_0000_FFFF_FFFF) begin
      r = 64'h0000_0000_FFFF_FFFF;
      ref_sat++;
    end
    ref_mem[a] = DW'(r);
    e.addr = a;
    e.data = DW'(r);
    exp_q.push_back(e);
    ref_upd++;
  endfunction

  // SRAM responder: acks after a random wait, returns read data a random number
  // of cycles later, optionally injects stray rd_vld pulses, and logs accesses.
  initial begin
    int            wait_cnt = 0;
    int            ack_tgt  = 0;
    int            rd_cnt   = 0;
    int            rdvld_cyc = 0;
    logic [AW-1:0] rd_addr  = '0;
    bit            prev_req = 0, prev_ack = 0, prev_rw = 1;
    logic [AW-1:0] prev_addr = '0;
    logic [DW-1:0] prev_wd  = '0;
    acc_t          e;
    sram_ack     = 1'b0;
    sram_rd_vld  = 1'b0;
    sram_rd_data = '0;
    forever begin
      @(negedge clk);
      sram_ack     = 1'b0;
      sram_rd_vld  = 1'b0;
      sram_rd_data = DW'({$urandom(), $urandom()});
      if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) begin
          sram_rd_vld  = 1'b1;
          sram_rd_data = mem_rd(rd_addr);
          rdvld_cyc    = cyc;
        end
      end else if (spur_en && $urandom_range(0, 7) == 0) begin
        sram_rd_vld = 1'b1;
      end
      if (sram_req && prev_req && !prev_ack &&
          (sram_addr !== prev_addr || sram_rd_wr_L !== prev_rw || sram_wr_data !== prev_wd))
        proto_err++;
      if (sram_req && prev_ack) proto_err++;
      if (sram_req && !prev_req) begin
        wait_cnt = 0;
        ack_tgt  = $urandom_range(ack_min, ack_max);
        if (!sram_rd_wr_L) wr_lat_q.push_back(cyc - rdvld_cyc);
      end
      if (sram_req && !reset && !prev_ack) begin
        if (wait_cnt >= ack_tgt) begin
          sram_ack = 1'b1;
          e.wr   = !sram_rd_wr_L;
          e.addr = sram_addr;
          e.data = sram_wr_data;
          log_q.push_back(e);
          if (sram_rd_wr_L) begin
            rd_cnt  = $urandom_range(rd_min, rd_max) + 1;
            rd_addr = sram_addr;
          end else begin
            mem[sram_addr] = sram_wr_data;
          end
        end else begin
          wait_cnt++;
        end
      end
      prev_req  = sram_req;
      prev_ack  = sram_ack;
      prev_rw   = sram_rd_wr_L;
      prev_addr = sram_addr;
      prev_wd   = sram_wr_data;
    end
  end

  // ---------------- stimulus helpers (no checking inside) ----------------
  // Called at a negedge; returns at the next negedge after acceptance. waited=-1 on timeout.
  task automatic push(input logic [AW-1:0] a, input logic [1:0] f, input logic [31:0] v,
                      output int waited);
    req_vld   = 1'b1;
    req_addr  = a;
    req_func  = f;
    req_value = v;
    waited    = 0;
    while (!req_rdy && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    if (req_rdy) model_accept(a, f, v);
    else waited = -1;
    @(negedge clk);
    req_vld   = 1'b0;
    req_value = $urandom;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int n = 0;
    repeat (3) @(negedge clk);
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    ok = !busy;
  endtask

  task automatic take_pair(output bit ok, output logic [AW-1:0] ra, output logic [AW-1:0] wa,
                           output logic [DW-1:0] wd);
    acc_t r, w;
    ok = 0;
    ra = 'x;
    wa = 'x;
    wd = 'x;
    if (log_q.size() >= 2) begin
      r  = log_q.pop_front();
      w  = log_q.pop_front();
      ok = !r.wr && w.wr;
      ra = r.addr;
      wa = w.addr;
      wd = w.data;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    tests++; if (req_rdy !== 1'b1) begin fails++; $display("FAIL reset_req_rdy: got %b want 1", req_rdy); end
    tests++; if (sram_req !== 1'b0) begin fails++; $display("FAIL reset_sram_req: got %b want 0", sram_req); end
    tests++; if (sram_rd_wr_L !== 1'b1) begin fails++; $display("FAIL reset_rd_wr_L: got %b want 1", sram_rd_wr_L); end
    tests++; if (sram_addr !== '0) begin fails++; $display("FAIL reset_addr: got %h want 0", sram_addr); end
    tests++; if (sram_wr_data !== '0) begin fails++; $display("FAIL reset_wr_data: got %h want 0", sram_wr_data); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if (num_updates !== 32'd0) begin fails++; $display("FAIL reset_num_updates: got %0d want 0", num_updates); end
    tests++; if (num_saturated !== 32'd0) begin fails++; $display("FAIL reset_num_saturated: got %0d want 0", num_saturated); end
  endtask

  task automatic test_functions();
    int            w;
    bit            ok;
    logic [AW-1:0] ra, wa;
    logic [DW-1:0] wd;
    logic [AW-1:0] ea [4];
    logic [DW-1:0] ed [4];
    ack_min = 0; ack_max = 2; rd_min = 0; rd_max = 2; spur_en = 0;
    set_word(19'h1234, 36'h0_0000_0010);
    set_word(19'h2000, 36'h0_FFFF_FFF0);
    set_word(19'h3000, 36'h0_0000_0050);
    set_word(19'h4000, 36'hF_0000_0099);
    // ADD 0x10+5, also measuring push -> read-request latency
    push(19'h1234, FUNC_ADD, 32'h5, w);
    tests++; if (w !== 0) begin fails++; $display("FAIL add_accept: waited %0d want 0", w); end
    tests++; if (sram_req !== 1'b0) begin fails++; $display("FAIL read_lat_t1: sram_req %b want 0", sram_req); end
    @(negedge clk);
    tests++;
    if (sram_req !== 1'b1 || sram_rd_wr_L !== 1'b1 || sram_addr !== 19'h1234) begin
      fails++; $display("FAIL read_lat_t2: req=%b rw=%b addr=%h want 1 1 01234", sram_req, sram_rd_wr_L, sram_addr);
    end
    wait_idle(200, ok);
    tests++; if (!ok) begin fails++; $display("FAIL add_idle: busy=%b want 0", busy); end
    take_pair(ok, ra, wa, wd);
    tests++;
    if (!ok || ra !== 19'h1234 || wa !== 19'h1234 || wd !== 36'h0_0000_0015) begin
      fails++; $display("FAIL add_basic: ok=%b rd=%h wr=%h data=%h want 01234 01234 000000015", ok, ra, wa, wd);
    end
    tests++; if (num_updates !== 32'd1) begin fails++; $display("FAIL add_num_updates: got %0d want 1", num_updates); end
    // saturating ADD on its own
    push(19'h2000, FUNC_ADD, 32'h20, w);
    wait_idle(200, ok);
    tests++; if (num_saturated !== 32'd1) begin fails++; $display("FAIL add_sat_count: got %0d want 1", num_saturated); end
    push(19'h2000, FUNC_INC, 32'h1234_5678, w);
    push(19'h3000, FUNC_MAX, 32'h40, w);
    push(19'h4000, FUNC_SET, 32'h7, w);
    wait_idle(400, ok);
    ea = '{19'h2000, 19'h2000, 19'h3000, 19'h4000};
    ed = '{36'h0_FFFF_FFFF, 36'h0_FFFF_FFFF, 36'h0_0000_0050, 36'h0_0000_0007};
    for (int i = 0; i < 4; i++) begin
      take_pair(ok, ra, wa, wd);
      tests++;
      if (!ok || ra !== ea[i] || wa !== ea[i] || wd !== ed[i]) begin
        fails++; $display("FAIL func_seq[%0d]: ok=%b rd=%h wr=%h data=%h want addr=%h data=%h", i, ok, ra, wa, wd, ea[i], ed[i]);
      end
    end
    tests++; if (num_saturated !== 32'd2) begin fails++; $display("FAIL inc_sat_count: got %0d want 2", num_saturated); end
    tests++; if (num_updates !== 32'd5) begin fails++; $display("FAIL func_num_updates: got %0d want 5", num_updates); end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    int            w [6];
    bit            ok;
    logic [AW-1:0] ra, wa;
    logic [DW-1:0] wd;
    ack_min = 3; ack_max = 3; rd_min = 0; rd_max = 0; spur_en = 0;
    set_word(19'h0055, 36'd100);
    for (int i = 0; i < 5; i++) push(19'h0055, FUNC_INC, 32'h0, w[i]);
    for (int i = 0; i < 5; i++) begin
      tests++; if (w[i] !== 0) begin fails++; $display("FAIL b2b_accept[%0d]: waited %0d want 0", i, w[i]); end
    end
    tests++; if (req_rdy !== 1'b0) begin fails++; $display("FAIL b2b_full: req_rdy %b want 0", req_rdy); end
    // sixth request is held by upstream until a pop frees a slot
    push(19'h0055, FUNC_INC, 32'h0, w[5]);
    tests++; if (w[5] <= 0) begin fails++; $display("FAIL b2b_held_push: waited %0d want >0", w[5]); end
    wait_idle(400, ok);
    tests++; if (!ok) begin fails++; $display("FAIL b2b_idle: busy=%b want 0", busy); end
    for (int i = 0; i < 6; i++) begin
      take_pair(ok, ra, wa, wd);
      tests++;
      if (!ok || ra !== 19'h0055 || wa !== 19'h0055 || wd !== DW'(101 + i)) begin
        fails++; $display("FAIL b2b_seq[%0d]: ok=%b rd=%h wr=%h data=%0d want 00055 %0d", i, ok, ra, wa, wd, 101 + i);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_random();
    int            w, n, bad;
    bit            ok;
    logic [AW-1:0] ra, wa, a;
    logic [DW-1:0] wd;
    logic [31:0]   v;
    exp_q.delete(); log_q.delete(); wr_lat_q.delete();
    ack_min = 0; ack_max = 3; rd_min = 0; rd_max = 3; spur_en = 1;
    for (int i = 0; i < 8; i++) set_word(AW'(19'h100 + i), DW'({$urandom_range(0, 15), $urandom()}));
    for (int i = 0; i < 150; i++) begin
      a = AW'(19'h100 + $urandom_range(0, 7));
      v = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom();
      push(a, 2'($urandom_range(0, 3)), v, w);
      tests++; if (w < 0) begin fails++; $display("FAIL rand_push_timeout[%0d]: req_rdy stuck low", i); end
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
    end
    wait_idle(4000, ok);
    tests++; if (!ok) begin fails++; $display("FAIL rand_idle: busy=%b want 0", busy); end
    n = exp_q.size();
    tests++; if (log_q.size() !== 2 * n) begin fails++; $display("FAIL rand_access_count: got %0d want %0d", log_q.size(), 2 * n); end
    for (int i = 0; i < n; i++) begin
      take_pair(ok, ra, wa, wd);
      tests++;
      if (!ok || ra !== exp_q[i].addr || wa !== exp_q[i].addr || wd !== exp_q[i].data) begin
        fails++; $display("FAIL rand_update[%0d]: ok=%b rd=%h wr=%h data=%h want addr=%h data=%h", i, ok, ra, wa, wd, exp_q[i].addr, exp_q[i].data);
      end
    end
    tests++; if (num_updates !== 32'(ref_upd)) begin fails++; $display("FAIL rand_num_updates: got %0d want %0d", num_updates, ref_upd); end
    tests++; if (num_saturated !== 32'(ref_sat)) begin fails++; $display("FAIL rand_num_saturated: got %0d want %0d", num_saturated, ref_sat); end
    tests++; if (proto_err !== 0) begin fails++; $display("FAIL sram_protocol: %0d violations want 0", proto_err); end
    bad = 0;
    foreach (wr_lat_q[i]) if (wr_lat_q[i] != 1) bad++;
    tests++; if (bad !== 0) begin fails++; $display("FAIL write_req_latency: %0d writes not 1 cycle after rd_vld", bad); end
    exp_q.delete();
    spur_en = 0;
  endtask

  task automatic test_reset_abort();
    int            w, n;
    bit            ok;
    logic [AW-1:0] ra, wa;
    logic [DW-1:0] wd;
    logic [DW-1:0] snap [logic [AW-1:0]];
    ack_min = 0; ack_max = 0; rd_min = 6; rd_max = 6; spur_en = 0;
    set_word(19'h0077, 36'h0_0000_0100);
    snap = ref_mem;
    log_q.delete();
    push(19'h0077, FUNC_INC, 32'h0, w);
    push(19'h0077, FUNC_ADD, 32'h9, w);
    push(19'h0077, FUNC_MAX, 32'hFFFF, w);
    n = 0;
    while (log_q.size() == 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    tests++; if (log_q.size() !== 1 || log_q[0].wr !== 1'b0) begin fails++; $display("FAIL abort_setup: %0d accesses want 1 read", log_q.size()); end
    // engine is now waiting for read data with two requests queued
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    tests++; if (log_q.size() !== 1) begin fails++; $display("FAIL abort_no_write: %0d accesses want 1", log_q.size()); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy: got %b want 0", busy); end
    tests++; if (num_updates !== 32'd0 || num_saturated !== 32'd0) begin fails++; $display("FAIL abort_counters: upd=%0d sat=%0d want 0 0", num_updates, num_saturated); end
    tests++; if (req_rdy !== 1'b1 || sram_req !== 1'b0) begin fails++; $display("FAIL abort_port: rdy=%b req=%b want 1 0", req_rdy, sram_req); end
    tests++; if (mem_rd(19'h0077) !== 36'h0_0000_0100) begin fails++; $display("FAIL abort_mem: got %h want 000000100", mem_rd(19'h0077)); end
    ref_mem = snap;
    exp_q.delete();
    log_q.delete();
    ref_upd = 0;
    ref_sat = 0;
    // engine recovers cleanly after the abort
    push(19'h0077, FUNC_ADD, 32'h23, w);
    wait_idle(200, ok);
    take_pair(ok, ra, wa, wd);
    tests++;
    if (!ok || ra !== 19'h0077 || wa !== 19'h0077 || wd !== 36'h0_0000_0123) begin
      fails++; $display("FAIL post_abort_add: ok=%b rd=%h wr=%h data=%h want 00077 00077 000000123", ok, ra, wa, wd);
    end
    tests++; if (num_updates !== 32'd1) begin fails++; $display("FAIL post_abort_updates: got %0d want 1", num_updates); end
  endtask

  initial begin
    reset     = 1'b1;
    req_vld   = 1'b0;
    req_addr  = '0;
    req_func  = '0;
    req_value = '0;
    test_reset();
    test_functions();
    test_back_to_back();
    test_random();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    fails++;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end

endmodule
